ndata_compactor: RTL

Removes holes from an `ndata_i` stream: elements whose `keep` bit is clear are dropped, and kept elements are repacked densely in arrival order. Every output beat has all `keep` bits set, except the final beat of a packet, which has a contiguous low `keep` prefix. It sits directly upstream of the 8→16 width converter, which requires contiguous low-aligned `keep` on its input. It is used after filter and select stages that clear arbitrary lanes.

---
 rtl/ndata_compactor.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ndata_compactor.sv
// Stream compactor: drops lanes whose keep bit is clear and repacks kept elements densely,
// emitting full beats plus a low-aligned partial beat at the end of each packet.
module ndata_compactor #(
  parameter type         data_t = logic [7:0],
  parameter int unsigned WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  data_t [WIDTH-1:0]       in_data,
  input  logic  [WIDTH-1:0]       in_keep,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output data_t [WIDTH-1:0]       out_data,
  output logic  [WIDTH-1:0]       out_keep,
  output logic                    out_last
);

  localparam int unsigned DW  = $bits(data_t);
  localparam int unsigned BUF = 2 * WIDTH - 1;
  localparam int unsigned CW  = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] WidthC = CW'(WIDTH);

  typedef enum logic {StAccum, StFlush} state_e;

  state_e                 state_q, state_d;
  data_t  [BUF-1:0]       pend_q, pend_d;
  logic   [CW-1:0]        cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic   [WIDTH-1:0]     out_keep_q, out_keep_d;
  data_t  [WIDTH-1:0]     out_data_q, out_data_d;

  data_t  [WIDTH-1:0]     packed_in;
  logic   [CW-1:0]        pop;
  logic   [CW-1:0]        c;
  logic   [BUF*DW-1:0]    ext;
  data_t  [BUF-1:0]       merged;
  int unsigned            shamt;
  logic                   out_free;
  logic                   accept;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == StAccum) && out_free && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_keep  = out_keep_q;
  assign out_data  = out_data_q;

  // Pending slots at or above cnt are always zero, so appending is a shifted OR and unused
  // output lanes come out as zero without extra masking.
  always_comb begin
    packed_in = '0;
    pop       = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (in_keep[j]) begin
        packed_in[pop[CW-2:0]] = in_data[j];
        pop = pop + CW'(1);
      end
    end
    c               = cnt_q + pop;
    ext             = '0;
    ext[WIDTH*DW-1:0] = packed_in;
    shamt           = DW * 32'(cnt_q);
    merged          = pend_q | (ext << shamt);
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_keep_d  = out_keep_q;
    out_data_d  = out_data_q;
    if (out_free) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (c >= WidthC) begin
        out_data_d  = merged[WIDTH-1:0];
        out_keep_d  = {WIDTH{1'b1}};
        out_last_d  = in_last && (c == WidthC);
        out_valid_d = 1'b1;
        pend_d      = merged >> (WIDTH * DW);
        cnt_d       = c - WidthC;
        if (in_last && (c != WidthC)) begin
          state_d = StFlush;
        end
      end else if (in_last) begin
        out_data_d  = merged[WIDTH-1:0];
        out_keep_d  = ~({WIDTH{1'b1}} << c);
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        pend_d      = '0;
        cnt_d       = '0;
      end else begin
        pend_d = merged;
        cnt_d  = c;
      end
    end else if ((state_q == StFlush) && out_free) begin
      out_data_d  = pend_q[WIDTH-1:0];
      out_keep_d  = ~({WIDTH{1'b1}} << cnt_q);
      out_last_d  = 1'b1;
      out_valid_d = 1'b1;
      pend_d      = '0;
      cnt_d       = '0;
      state_d     = StAccum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccum;
      pend_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_keep_q  <= out_keep_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
